mold_msg_collect: RTL



---
 rtl/mold_pkg.sv | 32 +++
 rtl/mold_lane_compact.sv | 15 +
 rtl/mold_msg_collect.sv | 135 +++++++++++++
 3 files changed

// File: rtl/mold_pkg.sv
// rtl/mold_pkg.sv - shared constants, FSM state type and lane-mask helpers for the MoldUDP64 message collector.
package mold_pkg;
  localparam int LEN        = 8;
  localparam int ML_W       = 16;
  localparam int AXI_DATA_W = 64;
  localparam int AXI_KEEP_W = AXI_DATA_W / LEN;
  localparam int LANE_W     = $clog2(AXI_KEEP_W);

  typedef enum logic {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // An empty mask reports lane 0 so the shift is a no-op.
  function automatic logic [LANE_W-1:0] lowest_lane(input logic [AXI_KEEP_W-1:0] mask);
    logic [LANE_W-1:0] idx;
    idx = '0;
    for (int i = AXI_KEEP_W - 1; i >= 0; i--) begin
      if (mask[i]) idx = LANE_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [LANE_W:0] popcount(input logic [AXI_KEEP_W-1:0] mask);
    logic [LANE_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < AXI_KEEP_W; i++) begin
      cnt = cnt + {{LANE_W{1'b0}}, mask[i]};
    end
    return cnt;
  endfunction
endpackage

// File: rtl/mold_lane_compact.sv
// rtl/mold_lane_compact.sv - right-aligns the valid lane run of a beat to lane 0 and counts its bytes.
module mold_lane_compact
  import mold_pkg::*;
(
  input  logic [AXI_KEEP_W-1:0] i_mask,
  input  logic [AXI_DATA_W-1:0] i_data,
  output logic [AXI_DATA_W-1:0] o_data,
  output logic [LANE_W:0]       o_cnt
);
  logic [LANE_W-1:0] w_lo;

  assign w_lo   = lowest_lane(i_mask);
  assign o_data = i_data >> (LEN * int'(w_lo));
  assign o_cnt  = popcount(i_mask);
endmodule

// File: rtl/mold_msg_collect.sv
// rtl/mold_msg_collect.sv - reassembles MoldUDP64 messages spread over beats into one byte-0-aligned buffer
// and emits each complete (or truncated) message as a single-cycle pulse.
module mold_msg_collect
  import mold_pkg::*;
#(
  parameter int AXI_DATA_W = mold_pkg::AXI_DATA_W,
  parameter int AXI_KEEP_W = AXI_DATA_W / 8,
  parameter int ML_W       = mold_pkg::ML_W,
  parameter int MSG_MAX_B  = 64,
  parameter int CNT_W      = $clog2(MSG_MAX_B + 1)
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   mold_msg_v_i,
  input  logic                   mold_msg_start_i,
  input  logic [ML_W-1:0]        mold_msg_len_i,
  input  logic [AXI_KEEP_W-1:0]  mold_msg_mask_i,
  input  logic [AXI_DATA_W-1:0]  mold_msg_data_i,
  output logic                   itch_msg_v_o,
  output logic [ML_W-1:0]        itch_msg_len_o,
  output logic [8*MSG_MAX_B-1:0] itch_msg_data_o,
  output logic                   itch_msg_err_o
);
  localparam int BUF_W = 8 * MSG_MAX_B;

  state_t           r_state, w_state_nxt;
  logic             r_pend;
  logic [ML_W-1:0]  r_cnt, r_exp;
  logic [BUF_W-1:0] r_buf;
  logic             r_v, r_err;
  logic [ML_W-1:0]  r_len;
  logic [BUF_W-1:0] r_data;

  logic [AXI_DATA_W-1:0] w_cdata;
  logic [LANE_W:0]       w_pop;

  mold_lane_compact u_compact (
    .i_mask (mold_msg_mask_i),
    .i_data (mold_msg_data_i),
    .o_data (w_cdata),
    .o_cnt  (w_pop)
  );

  logic             w_start, w_app, w_trunc, w_old_emit, w_done;
  logic [ML_W-1:0]  w_base_cnt, w_base_exp, w_room, w_n, w_app_cnt;
  logic [ML_W:0]    w_sum;
  logic [BUF_W-1:0] w_base_buf, w_app_buf;
  logic [CNT_W-1:0] w_wr_lo;
  logic             w_emit, w_emit_err;
  logic [ML_W-1:0]  w_emit_len;
  logic [BUF_W-1:0] w_emit_buf;

  // A start always begins from an empty buffer, so the new message is cleared in the same cycle.
  assign w_start    = mold_msg_v_i & mold_msg_start_i;
  assign w_app      = w_start | (mold_msg_v_i & (r_state == COLLECT));
  assign w_trunc    = w_start & (r_state == COLLECT);
  assign w_old_emit = w_trunc | r_pend;
  assign w_base_cnt = w_start ? '0 : r_cnt;
  assign w_base_exp = w_start ? mold_msg_len_i : r_exp;
  assign w_base_buf = w_start ? '0 : r_buf;

  assign w_room    = w_base_exp - w_base_cnt;
  assign w_n       = (ML_W'(w_pop) < w_room) ? ML_W'(w_pop) : w_room;
  assign w_sum     = {1'b0, w_base_cnt} + {1'b0, w_n};
  assign w_app_cnt = w_sum[ML_W] ? '1 : w_sum[ML_W-1:0];
  assign w_done    = w_app & (w_app_cnt >= w_base_exp);
  assign w_wr_lo   = (w_base_cnt >= ML_W'(MSG_MAX_B)) ? CNT_W'(MSG_MAX_B) : CNT_W'(w_base_cnt);

  // Bytes landing at or beyond the buffer capacity are counted but never written.
  always_comb begin
    w_app_buf = w_base_buf;
    for (int j = 0; j < MSG_MAX_B; j++) begin
      if (((CNT_W+1)'(j) >= {1'b0, w_wr_lo}) &&
          ((CNT_W+1)'(j) < ({1'b0, w_wr_lo} + (CNT_W+1)'(w_n)))) begin
        w_app_buf[8*j +: 8] = w_cdata[8*((j - int'(w_wr_lo)) & (AXI_KEEP_W - 1)) +: 8];
      end
    end
  end

  // A truncation or a held-over completion owns the output this cycle; a message that
  // completes alongside it is parked in the buffer and emitted on the following cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_emit_len  = r_cnt;
    w_emit_err  = 1'b0;
    w_emit_buf  = r_buf;
    if (w_app) begin
      w_state_nxt = w_done ? IDLE : COLLECT;
    end
    if (w_old_emit) begin
      w_emit     = 1'b1;
      w_emit_len = (r_cnt < r_exp) ? r_cnt : r_exp;
      w_emit_err = w_trunc | (r_exp > ML_W'(MSG_MAX_B));
    end else if (w_done) begin
      w_emit     = 1'b1;
      w_emit_len = (w_app_cnt < w_base_exp) ? w_app_cnt : w_base_exp;
      w_emit_err = w_base_exp > ML_W'(MSG_MAX_B);
      w_emit_buf = w_app_buf;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state <= IDLE;
      r_pend  <= 1'b0;
      r_cnt   <= '0;
      r_exp   <= '0;
      r_buf   <= '0;
      r_v     <= 1'b0;
      r_err   <= 1'b0;
      r_len   <= '0;
      r_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pend  <= w_old_emit & w_done;
      r_v     <= w_emit;
      if (w_app) begin
        r_cnt <= w_app_cnt;
        r_exp <= w_base_exp;
        r_buf <= w_app_buf;
      end
      if (w_emit) begin
        r_len  <= w_emit_len;
        r_err  <= w_emit_err;
        r_data <= w_emit_buf;
      end
    end
  end

  assign itch_msg_v_o    = r_v;
  assign itch_msg_len_o  = r_len;
  assign itch_msg_err_o  = r_err;
  assign itch_msg_data_o = r_data;
endmodule
